fft_pixel_packer: RTL and testbench

Packs a serial pixel stream into four-lane complex integer beats for the FFT front end of the rigid motion-correction pipeline. Sits directly upstream of `fft_int2fp_converter`: its `data_0`..`data_3` outputs feed that stage's inputs. It counts columns and rows to mark row and frame ends, and it detects frames that restart early.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_pixel_packer_if.sv | 35 +++
 rtl/fft_pack_ctr.sv | 49 ++++
 rtl/fft_pixel_packer.sv | 127 ++++++++++++
 tb/tb_fft_pixel_packer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front end: lane count, complex sample
// layout and the pixel packer state encoding.
package fft_pkg;

    localparam int FFT_LANES = 4;
    localparam int CPLX_W    = 64;
    localparam int COMP_W    = 32;

    typedef struct packed {
        logic [COMP_W-1:0] im;
        logic [COMP_W-1:0] re;
    } cplx_int_t;

    typedef enum logic [0:0] {
        PACK_IDLE   = 1'b0,
        PACK_ACTIVE = 1'b1
    } pack_state_t;

endpackage

// File: rtl/fft_pixel_packer_if.sv
// Pixel-in / beat-out handshake bundle for fft_pixel_packer. The slave modport
// is the packer itself; the master modport is the pixel source and beat sink.
interface fft_pixel_packer_if #(
    parameter int PIX_W = 16
);
    import fft_pkg::*;

    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_sof;
    logic              pix_ready;

    logic [CPLX_W-1:0] data_0;
    logic [CPLX_W-1:0] data_1;
    logic [CPLX_W-1:0] data_2;
    logic [CPLX_W-1:0] data_3;
    logic              out_valid;
    logic              out_ready;
    logic              out_row_last;
    logic              out_frame_last;
    logic              sof_err;

    modport slave (
        input  pix_data, pix_valid, pix_sof, out_ready,
        output pix_ready, data_0, data_1, data_2, data_3,
               out_valid, out_row_last, out_frame_last, sof_err
    );

    modport master (
        output pix_data, pix_valid, pix_sof, out_ready,
        input  pix_ready, data_0, data_1, data_2, data_3,
               out_valid, out_row_last, out_frame_last, sof_err
    );

endinterface

// File: rtl/fft_pack_ctr.sv
// Beat-position counters for the pixel packer: column (beats in a row) and row
// counters with wrap-around, plus row-last / frame-last / frame-origin flags.
module fft_pack_ctr #(
    parameter int COLS = 128,
    parameter int ROWS = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic row_last,
    output logic frame_last,
    output logic at_origin
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;

    // A restart (clear) wins over advance so a new frame always starts at 0/0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (clear) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (advance) begin
            if (col_cnt == COL_MAX) begin
                col_cnt <= '0;
                if (row_cnt == ROW_MAX)
                    row_cnt <= '0;
                else
                    row_cnt <= row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    assign row_last   = (col_cnt == COL_MAX);
    assign frame_last = row_last && (row_cnt == ROW_MAX);
    assign at_origin  = (col_cnt == '0) && (row_cnt == '0);

endmodule

// File: rtl/fft_pixel_packer.sv
// Packs a serial pixel stream into four-lane complex beats with row/frame-last
// flags. Define FFT_PACK_SIGNED_EN to sign-extend pixels instead of zero-extend.
module fft_pixel_packer
    import fft_pkg::*;
#(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int PIX_W = 16
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    fft_pixel_packer_if.slave bus
);

    localparam int COLS = IMG_W / FFT_LANES;
    localparam logic [0:0] IDLE = PACK_IDLE;
    localparam logic [0:0] PACK = PACK_ACTIVE;

    logic [0:0]        state;
    logic [1:0]        lane_cnt;
    logic [COMP_W-1:0] lane_q0;
    logic [COMP_W-1:0] lane_q1;
    logic [COMP_W-1:0] lane_q2;
    cplx_int_t         beat_q [FFT_LANES];
    logic              out_valid_q;
    logic              row_last_q;
    logic              frame_last_q;
    logic              sof_err_q;

    logic [PIX_W-1:0]  pix_in;
    logic [COMP_W-1:0] pix_ext;
    logic              accept;
    logic              sof_restart;
    logic              beat_done;
    logic              drain;
    logic              row_last;
    logic              frame_last;
    logic              at_origin;

    assign pix_in = bus.pix_data;

`ifdef FFT_PACK_SIGNED_EN
    assign pix_ext = COMP_W'($signed(pix_in));
`else
    assign pix_ext = COMP_W'(pix_in);
`endif

    // Only the fourth pixel can stall, and only while the previous beat is stuck.
    assign bus.pix_ready = !((lane_cnt == 2'd3) && out_valid_q && !bus.out_ready);
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign sof_restart   = accept && bus.pix_sof;
    assign beat_done     = accept && !bus.pix_sof && (state == PACK) && (lane_cnt == 2'd3);
    assign drain         = out_valid_q && bus.out_ready;

    fft_pack_ctr #(
        .COLS (COLS),
        .ROWS (IMG_H)
    ) u_ctr (
        .clk        (s_axi_aclk),
        .rst        (s_axi_areset),
        .clear      (sof_restart),
        .advance    (beat_done),
        .row_last   (row_last),
        .frame_last (frame_last),
        .at_origin  (at_origin)
    );

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state     <= IDLE;
            lane_cnt  <= 2'd0;
            lane_q0   <= '0;
            lane_q1   <= '0;
            lane_q2   <= '0;
            sof_err_q <= 1'b0;
        end else if (sof_restart) begin
            // A frame start mid-frame drops the partial group and flags the error.
            if ((state == PACK) && !((lane_cnt == 2'd0) && at_origin))
                sof_err_q <= 1'b1;
            lane_q0  <= pix_ext;
            lane_cnt <= 2'd1;
            state    <= PACK;
        end else if (accept && (state == PACK)) begin
            case (lane_cnt)
                2'd0: lane_q0 <= pix_ext;
                2'd1: lane_q1 <= pix_ext;
                2'd2: lane_q2 <= pix_ext;
                default: begin
                    if (frame_last)
                        state <= IDLE;
                end
            endcase
            lane_cnt <= lane_cnt + 2'd1;
        end
    end

    // Loading a new beat takes priority over draining, so back-to-back keeps valid high.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int i = 0; i < FFT_LANES; i++)
                beat_q[i] <= '0;
            out_valid_q  <= 1'b0;
            row_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
        end else if (beat_done) begin
            beat_q[0]    <= '{im: '0, re: lane_q0};
            beat_q[1]    <= '{im: '0, re: lane_q1};
            beat_q[2]    <= '{im: '0, re: lane_q2};
            beat_q[3]    <= '{im: '0, re: pix_ext};
            out_valid_q  <= 1'b1;
            row_last_q   <= row_last;
            frame_last_q <= frame_last;
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.data_0         = beat_q[0];
    assign bus.data_1         = beat_q[1];
    assign bus.data_2         = beat_q[2];
    assign bus.data_3         = beat_q[3];
    assign bus.out_valid      = out_valid_q;
    assign bus.out_row_last   = row_last_q;
    assign bus.out_frame_last = frame_last_q;
    assign bus.sof_err        = sof_err_q;

endmodule

// File: tb/tb_fft_pixel_packer.sv
// Directed self-checking bench for fft_pixel_packer on an 8x2 image; expected
// extension results follow FFT_PACK_SIGNED_EN when the bench is built with it.
module tb_fft_pixel_packer;
    import fft_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 2;
    localparam int PIX_W = 16;

    typedef struct packed {
        logic [63:0] d0;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] d3;
        logic        rl;
        logic        fl;
    } beat_t;

    logic  clk;
    logic  rst;
    beat_t beats[$];
    int    checks = 0;
    int    passed = 0;

    fft_pixel_packer_if #(.PIX_W(PIX_W)) bus ();

    fft_pixel_packer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .bus          (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Beats are recorded mid-cycle when they are about to be handed off.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            beats.push_back({bus.data_0, bus.data_1, bus.data_2, bus.data_3,
                             bus.out_row_last, bus.out_frame_last});
    end

    function automatic beat_t mk(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d,
                                 input logic rl, input logic fl);
        return {32'd0, a, 32'd0, b, 32'd0, c, 32'd0, d, rl, fl};
    endfunction

    task automatic push(input logic [PIX_W-1:0] d, input logic sof);
        bit ok;
        ok = 1'b0;
        bus.pix_data  = d;
        bus.pix_sof   = sof;
        bus.pix_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = bus.pix_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            $display("[TB] FAIL push_timeout pixel=%0h pix_ready stayed %b, required 1", d, bus.pix_ready);
        end
    endtask

    task automatic idle(input int n);
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_row_last !== 1'b0 || bus.out_frame_last !== 1'b0)
            $display("[TB] FAIL reset_flags got v=%b rl=%b fl=%b, required 0 0 0",
                     bus.out_valid, bus.out_row_last, bus.out_frame_last);
        else passed++;
        checks++;
        if (bus.pix_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b, required 1", bus.pix_ready);
        else passed++;
        checks++;
        if (bus.data_0 !== 64'd0 || bus.data_3 !== 64'd0 || bus.sof_err !== 1'b0)
            $display("[TB] FAIL reset_data got d0=%h d3=%h err=%b, required 0", bus.data_0, bus.data_3, bus.sof_err);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pix_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("[TB] FAIL post_reset got ready=%b v=%b, required 1 0", bus.pix_ready, bus.out_valid);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        beat_t exp;
        beats.delete();
        bus.out_ready = 1'b1;
        push(16'd1, 1'b1);
        for (int p = 2; p <= 16; p++) push(16'(p), 1'b0);
        idle(3);
        checks++;
        if (beats.size() != 4) $display("[TB] FAIL basic_count got %0d beats, required 4", beats.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            exp = mk(32'(4*i+1), 32'(4*i+2), 32'(4*i+3), 32'(4*i+4), (i % 2) == 1, i == 3);
            checks++;
            if (beats.size() <= i) $display("[TB] FAIL basic_beat%0d missing, required %h", i, exp);
            else if (beats[i] !== exp) $display("[TB] FAIL basic_beat%0d got %h, required %h", i, beats[i], exp);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        beat_t exp;
        bit    stall_ok;
        beats.delete();
        bus.out_ready = 1'b1;
        push(16'd1, 1'b1);
        for (int p = 2; p <= 4; p++) push(16'(p), 1'b0);
        bus.out_ready = 1'b0;
        for (int p = 5; p <= 7; p++) push(16'(p), 1'b0);
        bus.pix_data  = 16'd8;
        bus.pix_sof   = 1'b0;
        bus.pix_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pix_ready !== 1'b0) $display("[TB] FAIL bp_ready_drop got %b, required 0", bus.pix_ready);
        else passed++;
        stall_ok = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.pix_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.data_0 !== 64'd1 || bus.data_3 !== 64'd4)
                stall_ok = 1'b0;
        end
        checks++;
        if (!stall_ok) $display("[TB] FAIL bp_hold got ready=%b v=%b d0=%h d3=%h, required 0 1 1 4",
                                bus.pix_ready, bus.out_valid, bus.data_0, bus.data_3);
        else passed++;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int p = 8; p <= 16; p++) push(16'(p), 1'b0);
        idle(3);
        checks++;
        if (beats.size() != 4) $display("[TB] FAIL bp_count got %0d beats, required 4", beats.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            exp = mk(32'(4*i+1), 32'(4*i+2), 32'(4*i+3), 32'(4*i+4), (i % 2) == 1, i == 3);
            checks++;
            if (beats.size() <= i) $display("[TB] FAIL bp_beat%0d missing, required %h", i, exp);
            else if (beats[i] !== exp) $display("[TB] FAIL bp_beat%0d got %h, required %h", i, beats[i], exp);
            else passed++;
        end
    endtask

    task automatic test_pre_sof_discard();
        beat_t exp;
        beats.delete();
        bus.out_ready = 1'b1;
        for (int p = 0; p < 7; p++) push(16'(8'h10 + p), 1'b0);
        idle(3);
        @(negedge clk);
        checks++;
        if (beats.size() != 0 || bus.out_valid !== 1'b0)
            $display("[TB] FAIL presof_discard got %0d beats v=%b, required 0 0", beats.size(), bus.out_valid);
        else passed++;
        @(posedge clk);
        #1;
        push(16'h00AA, 1'b1);
        push(16'h00BB, 1'b0);
        push(16'h00CC, 1'b0);
        push(16'h00DD, 1'b0);
        idle(2);
        exp = mk(32'hAA, 32'hBB, 32'hCC, 32'hDD, 1'b0, 1'b0);
        checks++;
        if (beats.size() != 1) $display("[TB] FAIL presof_count got %0d beats, required 1", beats.size());
        else if (beats[0] !== exp) $display("[TB] FAIL presof_beat got %h, required %h", beats[0], exp);
        else passed++;
    endtask

    task automatic test_sof_err();
        beat_t exp0, exp1;
        pulse_reset();
        beats.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.sof_err !== 1'b0) $display("[TB] FAIL soferr_clear got %b, required 0", bus.sof_err);
        else passed++;
        @(posedge clk);
        #1;
        push(16'd1, 1'b1);
        for (int p = 2; p <= 5; p++) push(16'(p), 1'b0);
        push(16'h60, 1'b1);
        push(16'h61, 1'b0);
        push(16'h62, 1'b0);
        push(16'h63, 1'b0);
        idle(2);
        checks++;
        if (bus.sof_err !== 1'b1) $display("[TB] FAIL soferr_set got %b, required 1", bus.sof_err);
        else passed++;
        exp0 = mk(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0);
        exp1 = mk(32'h60, 32'h61, 32'h62, 32'h63, 1'b0, 1'b0);
        checks++;
        if (beats.size() != 2) $display("[TB] FAIL soferr_count got %0d beats, required 2", beats.size());
        else if (beats[0] !== exp0 || beats[1] !== exp1)
            $display("[TB] FAIL soferr_beats got %h / %h, required %h / %h", beats[0], beats[1], exp0, exp1);
        else passed++;
        for (int p = 0; p < 4; p++) push(16'(8'h70 + p), 1'b0);
        idle(5);
        checks++;
        if (bus.sof_err !== 1'b1) $display("[TB] FAIL soferr_sticky got %b, required 1", bus.sof_err);
        else passed++;
        pulse_reset();
        @(negedge clk);
        checks++;
        if (bus.sof_err !== 1'b0) $display("[TB] FAIL soferr_reset got %b, required 0", bus.sof_err);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_extension();
        beat_t exp;
        pulse_reset();
        beats.delete();
        bus.out_ready = 1'b1;
        push(16'hFFFF, 1'b1);
        push(16'h8000, 1'b0);
        push(16'h7FFF, 1'b0);
        push(16'h0001, 1'b0);
        idle(2);
`ifdef FFT_PACK_SIGNED_EN
        exp = mk(32'hFFFFFFFF, 32'hFFFF8000, 32'h00007FFF, 32'h00000001, 1'b0, 1'b0);
`else
        exp = mk(32'h0000FFFF, 32'h00008000, 32'h00007FFF, 32'h00000001, 1'b0, 1'b0);
`endif
        checks++;
        if (beats.size() != 1) $display("[TB] FAIL ext_count got %0d beats, required 1", beats.size());
        else if (beats[0] !== exp) $display("[TB] FAIL ext_beat got %h, required %h", beats[0], exp);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        beat_t exp;
        pulse_reset();
        beats.delete();
        bus.out_ready = 1'b0;
        push(16'd1, 1'b1);
        for (int p = 2; p <= 6; p++) push(16'(p), 1'b0);
        idle(1);
        checks++;
        if (bus.out_valid !== 1'b1) $display("[TB] FAIL midrst_pre got v=%b, required 1", bus.out_valid);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_row_last !== 1'b0 || bus.out_frame_last !== 1'b0 ||
            bus.data_0 !== 64'd0 || bus.data_3 !== 64'd0 || bus.sof_err !== 1'b0)
            $display("[TB] FAIL midrst_async got v=%b d0=%h d3=%h, required 0 0 0",
                     bus.out_valid, bus.data_0, bus.data_3);
        else passed++;
        checks++;
        if (bus.pix_ready !== 1'b1) $display("[TB] FAIL midrst_ready got %b, required 1", bus.pix_ready);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        push(16'h77, 1'b1);
        push(16'h78, 1'b0);
        push(16'h79, 1'b0);
        push(16'h7A, 1'b0);
        idle(2);
        exp = mk(32'h77, 32'h78, 32'h79, 32'h7A, 1'b0, 1'b0);
        checks++;
        if (beats.size() != 1) $display("[TB] FAIL midrst_count got %0d beats, required 1", beats.size());
        else if (beats[0] !== exp) $display("[TB] FAIL midrst_beat got %h, required %h", beats[0], exp);
        else passed++;
    endtask

    initial begin
        rst           = 1'b1;
        bus.pix_data  = '0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_pre_sof_discard();
        test_sof_err();
        test_extension();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
